// File: rtl/ram_block_ctrl_pkg.sv
// Shared sizing and state encoding for the block-transfer controller and its async RAM.
// Any RAM model that sits behind the controller should size itself from these constants.
package ram_block_ctrl_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DEPTH  = 11;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WR_ACCEPT  = 3'd1,
    S_WR_STROBE  = 3'd2,
    S_RD_ADDR    = 3'd3,
    S_RD_CAPTURE = 3'd4,
    S_RD_WAIT    = 3'd5,
    S_DONE       = 3'd6
  } state_e;

endpackage

// File: rtl/ram_block_ctrl.sv
// Block-transfer controller in front of a level-sensitive async RAM.
// Streams a command-sized block into the RAM or out of it, with every RAM-side output registered.
//
// state        | meaning
// -------------+----------------------------------------------------------
// S_IDLE       | cmd_ready=1, waiting for a command; range-checks it
// S_WR_ACCEPT  | in_ready=1, waiting for the next write byte
// S_WR_STROBE  | mem_we high for this single cycle, address/data stable
// S_RD_ADDR    | mem_addr registered from ptr
// S_RD_CAPTURE | RAM output has settled for a full cycle, capture it
// S_RD_WAIT    | out_valid held until out_ready is sampled high
// S_DONE       | done pulse, then back to idle
module ram_block_ctrl
  import ram_block_ctrl_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DEPTH  = RAM_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W-1:0] cmd_base,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] out_data_d;
  logic              mem_we_d, out_valid_d, done_d, err_d;

  // One extra bit so base+len cannot wrap past the depth limit.
  logic [ADDR_W:0]   cmd_end;
  logic [ADDR_W:0]   depth_lim;
  logic              last_word;

  assign cmd_end   = {1'b0, cmd_base} + {1'b0, cmd_len};
  assign depth_lim = (ADDR_W+1)'(DEPTH);
  assign last_word = (cnt_q == ADDR_W'(1));

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_WR_ACCEPT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      mem_we    <= mem_we_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
      done      <= done_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    mem_we_d    = 1'b0;
    out_data_d  = out_data;
    out_valid_d = out_valid;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          ptr_d = cmd_base;
          cnt_d = cmd_len;
          if (cmd_end > depth_lim) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (cmd_dir) begin
            state_d = S_RD_ADDR;
          end else begin
            state_d = S_WR_ACCEPT;
          end
        end
      end

      S_WR_ACCEPT: begin
        if (in_valid) begin
          mem_addr_d  = ptr_q;
          mem_wdata_d = in_data;
          mem_we_d    = 1'b1;
          state_d     = S_WR_STROBE;
        end
      end

      S_WR_STROBE: begin
        ptr_d = ptr_q + ADDR_W'(1);
        cnt_d = cnt_q - ADDR_W'(1);
        if (last_word) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_WR_ACCEPT;
        end
      end

      S_RD_ADDR: begin
        mem_addr_d = ptr_q;
        state_d    = S_RD_CAPTURE;
      end

      S_RD_CAPTURE: begin
        out_data_d  = mem_rdata;
        out_valid_d = 1'b1;
        state_d     = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          ptr_d       = ptr_q + ADDR_W'(1);
          cnt_d       = cnt_q - ADDR_W'(1);
          if (last_word) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD_ADDR;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ram_block_ctrl.sv
// Bench for ram_block_ctrl driving a behavioural async RAM; write and read traffic is
// scoreboarded through queues filled at stimulus time and drained by a negedge monitor.
module tb_ram_block_ctrl;
  import ram_block_ctrl_pkg::*;

  localparam int DW    = RAM_DATA_W;
  localparam int AW    = RAM_ADDR_W;
  localparam int DEPTH = RAM_DEPTH;

  logic          clk;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_dir;
  logic [AW-1:0] cmd_base, cmd_len;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          busy, done, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  ram_block_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_base  (cmd_base),
    .cmd_len   (cmd_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata)
  );

  // Level-sensitive RAM load; only the first DEPTH words are real.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  assign mem_rdata = ram[mem_addr];
  always @* begin
    if (mem_we === 1'b1 && mem_addr < AW'(DEPTH)) ram[mem_addr] = mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  logic [15:0] wr_q [$];
  logic [7:0]  rd_q [$];
  int          we_cyc_q [$];
  int          rv_cyc_q [$];
  int          we_total = 0, done_total = 0, err_total = 0;
  int          done_cyc = -1, cmd_cyc = 0;
  logic        prev_we = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

  always @(negedge clk) begin
    logic [15:0] ew;
    logic [7:0]  er;
    if (rst_n) begin
      if (mem_we) begin
        we_total++;
        we_cyc_q.push_back(cyc);
        chk("we_pulse_width", {31'b0, prev_we}, 32'd0);
        if (wr_q.size() == 0) chk("we_unexpected", 32'd1, 32'd0);
        else begin
          ew = wr_q.pop_front();
          chk("we_addr", {24'b0, mem_addr}, {24'b0, ew[15:8]});
          chk("we_data", {24'b0, mem_wdata}, {24'b0, ew[7:0]});
        end
      end
      if (out_valid && out_ready) begin
        rv_cyc_q.push_back(cyc);
        if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          er = rd_q.pop_front();
          chk("rd_data", {24'b0, out_data}, {24'b0, er});
        end
      end
      if (done) begin
        done_total++;
        done_cyc = cyc;
        chk("done_width", {31'b0, prev_done}, 32'd0);
      end
      if (err) begin
        err_total++;
        chk("err_width", {31'b0, prev_err}, 32'd0);
      end
    end
    prev_we   = mem_we;
    prev_done = done;
    prev_err  = err;
  end

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_mem_we"},    {31'b0, mem_we},    32'd0);
    chk({pfx, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
    chk({pfx, "_busy"},      {31'b0, busy},      32'd0);
    chk({pfx, "_in_ready"},  {31'b0, in_ready},  32'd0);
    chk({pfx, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({pfx, "_done"},      {31'b0, done},      32'd0);
    chk({pfx, "_err"},       {31'b0, err},       32'd0);
    chk({pfx, "_mem_addr"},  {24'b0, mem_addr},  32'd0);
    chk({pfx, "_mem_wdata"}, {24'b0, mem_wdata}, 32'd0);
    chk({pfx, "_out_data"},  {24'b0, out_data},  32'd0);
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that sampled the command.
  task automatic send_cmd(input logic dir, input logic [AW-1:0] base, input logic [AW-1:0] len);
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_base  = base;
    cmd_len   = len;
    @(posedge clk); #1;
    cmd_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk(tag, {31'b0, cmd_ready}, 32'd1);
  endtask

  task automatic write_block(input logic [AW-1:0] base, input int len, input logic [DW-1:0] d [4]);
    int n;
    for (int i = 0; i < len; i++) wr_q.push_back({base + AW'(i), d[i]});
    in_valid = 1'b1;
    in_data  = d[0];
    send_cmd(1'b0, base, AW'(len));
    for (int i = 0; i < len; i++) begin
      in_data = d[i];
      n = 0;
      while (!in_ready && n < 50) begin
        @(posedge clk); #1; n++;
      end
      chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, d0, e0, n;
    logic [DW-1:0] blk [4];

    for (int i = 0; i < (1 << AW); i++) ram[i] = DW'(8'h10 + i);
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("rst");
    @(posedge clk); #1;

    // Write 2..4 with in_valid held high.
    we_cyc_q.delete();
    w0 = we_total; d0 = done_total;
    blk = '{8'hA1, 8'hB2, 8'hC3, 8'h00};
    write_block(8'd2, 3, blk);
    wait_idle("wr_idle");
    chk("wr_strobes", we_total - w0, 32'd3);
    chk("wr_first_strobe", we_cyc_q[0], cmd_cyc + 1);
    chk("wr_spacing1", we_cyc_q[1] - we_cyc_q[0], 32'd2);
    chk("wr_spacing2", we_cyc_q[2] - we_cyc_q[1], 32'd2);
    chk("wr_done_timing", done_cyc, we_cyc_q[2] + 1);
    chk("wr_done_count", done_total - d0, 32'd1);
    chk("ram2", {24'b0, ram[2]}, 32'hA1);
    chk("ram3", {24'b0, ram[3]}, 32'hB2);
    chk("ram4", {24'b0, ram[4]}, 32'hC3);

    // Read back 2..4 with out_ready high all along.
    rv_cyc_q.delete();
    w0 = we_total; d0 = done_total;
    rd_q.push_back(8'hA1); rd_q.push_back(8'hB2); rd_q.push_back(8'hC3);
    out_ready = 1'b1;
    send_cmd(1'b1, 8'd2, 8'd3);
    wait_idle("rd_idle");
    chk("rd_first_latency", rv_cyc_q[0], cmd_cyc + 2);
    chk("rd_spacing1", rv_cyc_q[1] - rv_cyc_q[0], 32'd3);
    chk("rd_spacing2", rv_cyc_q[2] - rv_cyc_q[1], 32'd3);
    chk("rd_no_we", we_total - w0, 32'd0);
    chk("rd_done_count", done_total - d0, 32'd1);
    chk("rd_done_timing", done_cyc, rv_cyc_q[2] + 1);
    chk("rd_q_drained", rd_q.size(), 32'd0);

    // Read 0..1 with the consumer stalled for 5 cycles.
    out_ready = 1'b0;
    rd_q.push_back(8'h10); rd_q.push_back(8'h11);
    send_cmd(1'b1, 8'd0, 8'd2);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("stall_latency", cyc, cmd_cyc + 2);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_data",  {24'b0, out_data},  32'h10);
      chk("stall_addr",  {24'b0, mem_addr},  32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("stall_idle");
    chk("stall_q_drained", rd_q.size(), 32'd0);

    // Range check: rejected, including a sum that would wrap in ADDR_W bits.
    e0 = err_total; w0 = we_total; d0 = done_total;
    send_cmd(1'b0, 8'd9, 8'd3);
    @(negedge clk);
    chk("err_pulse", {31'b0, err}, 32'd1);
    chk("err_busy", {31'b0, busy}, 32'd0);
    chk("err_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    chk("err_clear", {31'b0, err}, 32'd0);
    @(posedge clk); #1;
    send_cmd(1'b1, 8'd250, 8'd10);
    @(negedge clk);
    chk("err_wrap_pulse", {31'b0, err}, 32'd1);
    @(posedge clk); #1;
    blk = '{8'h5A, 8'h00, 8'h00, 8'h00};
    write_block(8'd10, 1, blk);
    wait_idle("edge_idle");
    chk("err_count", err_total - e0, 32'd2);
    chk("edge_we_count", we_total - w0, 32'd1);
    chk("edge_done_count", done_total - d0, 32'd1);
    chk("ram10", {24'b0, ram[10]}, 32'h5A);

    // Zero-length command; in_valid offered but must not be consumed.
    w0 = we_total; d0 = done_total;
    in_valid = 1'b1; in_data = 8'hEE;
    send_cmd(1'b0, 8'd3, 8'd0);
    @(negedge clk);
    chk("len0_done", {31'b0, done}, 32'd1);
    chk("len0_in_ready", {31'b0, in_ready}, 32'd0);
    wait_idle("len0_idle");
    in_valid = 1'b0;
    chk("len0_done_count", done_total - d0, 32'd1);
    chk("len0_no_we", we_total - w0, 32'd0);
    chk("len0_ram3", {24'b0, ram[3]}, 32'hB2);

    // Reset while mem_we is high.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h77;
    send_cmd(1'b0, 8'd5, 8'd2);
    n = 0;
    while (!mem_we && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("strobe_seen", {31'b0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_vals("midrst");
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    chk("post_rst_ram5", {24'b0, ram[5]}, 32'h77);
    @(posedge clk); #1;
    send_cmd(1'b1, 8'd0, 8'd0);
    @(negedge clk);
    chk("post_rst_done", {31'b0, done}, 32'd1);

    chk("wr_q_empty", wr_q.size(), 32'd0);
    chk("rd_q_empty", rd_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
